conv_window_fetcher: RTL and testbench
======================================

CONV_WINDOW_FETCHER -- requirements
Module: conv_window_fetcher

Interface
REQ-001 SHALL have parameter IMG_W, default 6: image row stride in bytes; SHALL equal the RAM responder's fixed row stride.
REQ-002 SHALL have parameter IMG_H, default 6: image height in rows; IMG_W*IMG_H SHALL be <= 64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a full window sweep; sampled only in IDLE.
REQ-006 SHALL have port need_Data, output, 1 bit: window read request to the RAM responder.
REQ-007 SHALL have port Needed_Addr, output, 6 bits: top-left byte address of the requested window.
REQ-008 SHALL have port ram_data, input, 96 bits: 3x4-byte window returned by the RAM, valid one cycle after need_Data.
REQ-009 SHALL have port win_data, output, 96 bits: captured window; byte order matches ram_data, with the MSB byte at Needed_Addr.
REQ-010 SHALL have port win_valid, output, 1 bit: win_data is valid.
REQ-011 SHALL have port win_ready, input, 1 bit: the downstream consumer accepts win_data.
REQ-012 SHALL have port win_row, output, 3 bits: row index of the presented window.
REQ-013 SHALL have port win_col, output, 3 bits: column index of the presented window.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last window is accepted.

Function
REQ-016 SHALL implement an FSM with states IDLE, REQ, WAIT, HOLD and DONE.
REQ-017 In IDLE with start=1, SHALL clear row and col to 0 and go to REQ.
REQ-018 In REQ, SHALL drive need_Data=1 and Needed_Addr=row*IMG_W+col (6-bit result, no truncation for legal parameters), then go to WAIT.
REQ-019 need_Data SHALL be 0 in every state other than REQ.
REQ-020 In WAIT, SHALL register ram_data into win_data, and row/col into win_row/win_col, then go to HOLD.
REQ-021 In HOLD, SHALL drive win_valid=1 and hold win_data, win_row and win_col stable until win_valid&&win_ready.
REQ-022 On the HOLD handshake:
- if col < IMG_W-4: col+1, go to REQ;
- else if row < IMG_H-3: col=0, row+1, go to REQ;
- else go to DONE.
REQ-023 In DONE, SHALL drive done=1 for exactly one cycle, then go to IDLE.
REQ-024 Window count per sweep SHALL be (IMG_W-3)*(IMG_H-2), visited in row-major order.
REQ-025 With win_ready held high, SHALL present one window every 3 cycles (REQ, WAIT, HOLD).
REQ-026 start asserted outside IDLE, including in DONE, SHALL be ignored.
REQ-027 win_ready asserted outside HOLD SHALL have no effect.
REQ-028 Needed_Addr SHALL hold its last value outside REQ.
REQ-029 The system SHALL NOT write the RAM while busy=1; the block does not arbitrate RAM writes.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE from any state, including mid-sweep.
REQ-031 On reset, need_Data, win_valid, busy and done SHALL be 0; Needed_Addr, win_data, win_row, win_col, row and col SHALL be 0.
REQ-032 rst SHALL take priority over start and win_ready in the same cycle.

Structure
REQ-033 A shared package yolo_mem_pkg SHALL hold:
- the FSM state typedef;
- constants WIN_COLS=4, WIN_ROWS=3, WIN_BYTES=12, ADDR_W=6.
REQ-034 The row/col counter with its wrap and last-window detection SHALL be one sub-module, win_pos_counter (inputs: clear, advance; outputs: row, col, last).

Verification
REQ-035 SHALL be verified by the following directed scenarios, with IMG_W=6, IMG_H=6 and RAM preloaded so that byte[a]=a:
- First window: pulse start, win_ready=1 -> need_Data with Needed_Addr=0 one cycle after start; win_data=0x00010203_06070809_0C0D0E0F, win_row=0, win_col=0.
- Full sweep: pulse start, win_ready=1 -> exactly 12 handshakes at addresses 0,1,2,6,7,8,12,13,14,18,19,20; the last win_data=0x14151617_1A1B1C1D_20212223; done pulses once; busy falls the cycle after done.
- Backpressure: hold win_ready=0 for 5 cycles in HOLD -> win_valid stays 1, win_data unchanged, need_Data stays 0; release -> next Needed_Addr=1.
- Start ignored: assert start during HOLD and during DONE -> no restart; window count stays 12.
- Reset mid-sweep: assert rst in WAIT of window 5 -> all outputs 0 next cycle; a new start restarts at Needed_Addr=0.
- Throughput: win_ready tied high -> consecutive win_valid rising edges exactly 3 cycles apart.

Source files
------------

// File: rtl/yolo_mem_pkg.sv
// Shared types and constants for the convolution window fetch path.
package yolo_mem_pkg;

  localparam int WIN_COLS  = 4;
  localparam int WIN_ROWS  = 3;
  localparam int WIN_BYTES = 12;
  localparam int ADDR_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] win_addr(input logic [2:0] row,
                                                 input logic [2:0] col,
                                                 input int img_w);
    return ADDR_W'(int'(row) * img_w + int'(col));
  endfunction

endpackage

// File: rtl/win_pos_counter.sv
// Row-major window position counter; last flags the bottom-right window.
module win_pos_counter
  import yolo_mem_pkg::*;
#(
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  localparam logic [2:0] COL_MAX = 3'(IMG_W - WIN_COLS);
  localparam logic [2:0] ROW_MAX = 3'(IMG_H - WIN_ROWS);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  assign last    = col_end && row_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (!col_end) begin
        col <= col + 3'd1;
      end else if (!row_end) begin
        col <= '0;
        row <= row + 3'd1;
      end
    end
  end

endmodule

// File: rtl/conv_window_fetcher.sv
// Sweeps a 3x4-byte window across the image, fetching each from RAM and
// presenting it downstream with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | need_Data high, address of current window on Needed_Addr
// WAIT  | RAM data arriving, captured at end of cycle
// HOLD  | win_valid high until win_ready
// DONE  | one-cycle done pulse
module conv_window_fetcher
  import yolo_mem_pkg::*;
#(
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   need_Data,
  output logic [ADDR_W-1:0]      Needed_Addr,
  input  logic [WIN_BYTES*8-1:0] ram_data,
  output logic [WIN_BYTES*8-1:0] win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [2:0]             win_row,
  output logic [2:0]             win_col,
  output logic                   busy,
  output logic                   done
);

  fetch_state_t state;
  logic [2:0]   row;
  logic [2:0]   col;
  logic         last;
  logic         clear;
  logic         advance;

  assign clear   = (state == ST_IDLE) && start;
  assign advance = (state == ST_HOLD) && win_ready && !last;

  win_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Position only moves on entry to REQ, so the address is stable elsewhere.
  assign Needed_Addr = win_addr(row, col, IMG_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      need_Data <= 1'b0;
      win_data  <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_REQ;
            need_Data <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          state     <= ST_WAIT;
          need_Data <= 1'b0;
        end
        ST_WAIT: begin
          state     <= ST_HOLD;
          win_data  <= ram_data;
          win_row   <= row;
          win_col   <= col;
          win_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_REQ;
              need_Data <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          need_Data <= 1'b0;
          win_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_fetcher.sv
// Scoreboard bench: expected requests and windows are queued at start,
// a negedge monitor pops and compares them as the fetcher produces them.
module tb_conv_window_fetcher;

  localparam int W = 6;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        need_Data;
  logic [5:0]  Needed_Addr;
  logic [95:0] ram_data;
  logic [95:0] win_data;
  logic        win_valid;
  logic        win_ready;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        busy;
  logic        done;

  conv_window_fetcher #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .need_Data   (need_Data),
    .Needed_Addr (Needed_Addr),
    .ram_data    (ram_data),
    .win_data    (win_data),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] data;
    int          row;
    int          col;
  } win_t;

  logic [7:0] mem [64];
  win_t       win_q[$];
  int         addr_q[$];
  int         checks = 0;
  int         errors = 0;
  int         hs_count = 0;
  int         done_count = 0;
  int         cyc = 0;
  int         last_rise = -1;
  bit         tput_chk = 1'b0;
  bit         prev_valid = 1'b0;

  function automatic logic [95:0] model_window(input int a);
    logic [95:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        v = {v[87:0], mem[(a + r * W + c) % 64]};
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected sweep: every legal top-left position, row-major.
  task automatic push_sweep();
    win_t w;
    for (int r = 0; r <= H - 3; r++)
      for (int c = 0; c <= W - 4; c++) begin
        addr_q.push_back(r * W + c);
        w.data = model_window(r * W + c);
        w.row  = r;
        w.col  = c;
        win_q.push_back(w);
      end
  endtask

  // RAM responder: data valid the cycle after the request, garbage otherwise.
  always @(posedge clk) begin
    if (need_Data) ram_data <= model_window(int'(Needed_Addr));
    else           ram_data <= {$urandom, $urandom, $urandom};
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (need_Data) begin
        check("req_pending", 96'(addr_q.size() != 0), 96'd1);
        if (addr_q.size() != 0) check("req_addr", 96'(Needed_Addr), 96'(addr_q.pop_front()));
        check("req_while_valid", 96'(win_valid), 96'd0);
      end
      if (win_valid) begin
        check("valid_pending", 96'(win_q.size() != 0), 96'd1);
        if (win_q.size() != 0) begin
          check("win_data", win_data, win_q[0].data);
          check("win_row", 96'(win_row), 96'(win_q[0].row));
          check("win_col", 96'(win_col), 96'(win_q[0].col));
          if (win_ready) begin
            void'(win_q.pop_front());
            hs_count++;
          end
        end
      end
      if (win_valid && !prev_valid) begin
        if (tput_chk && last_rise >= 0) check("tput_gap", 96'(cyc - last_rise), 96'd3);
        last_rise = cyc;
      end
      if (done) done_count++;
    end
    prev_valid = win_valid;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_need"},  96'(need_Data),   96'd0);
    check({tag, "_addr"},  96'(Needed_Addr), 96'd0);
    check({tag, "_data"},  win_data,         96'd0);
    check({tag, "_valid"}, 96'(win_valid),   96'd0);
    check({tag, "_row"},   96'(win_row),     96'd0);
    check({tag, "_col"},   96'(win_col),     96'd0);
    check({tag, "_busy"},  96'(busy),        96'd0);
    check({tag, "_done"},  96'(done),        96'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    push_sweep();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits at negedges for done; rnd randomizes win_ready and start meanwhile.
  task automatic wait_done(input bit rnd, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (rnd) begin
        win_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 4) == 0);
      end
    end
    check("done_seen", 96'(ok), 96'd1);
  endtask

  // Called at the DONE negedge: start during DONE must be ignored.
  task automatic finish_sweep(input string tag);
    check({tag, "_busy_in_done"}, 96'(busy), 96'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_fall"}, 96'(busy), 96'd0);
    check({tag, "_done_fall"}, 96'(done), 96'd0);
    repeat (6) @(negedge clk);
    check({tag, "_idle_busy"}, 96'(busy), 96'd0);
    check({tag, "_hs_count"}, 96'(hs_count), 96'd12);
    check({tag, "_done_count"}, 96'(done_count), 96'd1);
    check({tag, "_win_q_empty"}, 96'(win_q.size()), 96'd0);
    check({tag, "_addr_q_empty"}, 96'(addr_q.size()), 96'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // First window, full sweep, throughput with win_ready tied high.
    win_ready = 1'b1;
    tput_chk = 1'b1;
    last_rise = -1;
    hs_count = 0;
    done_count = 0;
    pulse_start();
    @(negedge clk);
    check("first_need", 96'(need_Data), 96'd1);
    check("first_addr", 96'(Needed_Addr), 96'd0);
    @(negedge clk);
    @(negedge clk);
    check("first_valid", 96'(win_valid), 96'd1);
    check("first_data", win_data, 96'h00010203_06070809_0C0D0E0F);
    wait_done(1'b0, 100, ok);
    finish_sweep("sweep");
    tput_chk = 1'b0;

    // Backpressure, plus start during HOLD and DONE.
    win_ready = 1'b0;
    hs_count = 0;
    done_count = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", 96'(ok), 96'd1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 96'(win_valid), 96'd1);
      check("bp_no_req", 96'(need_Data), 96'd0);
      check("bp_data_hold", win_data, 96'h00010203_06070809_0C0D0E0F);
    end
    start = 1'b0;
    win_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (need_Data) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_next_req", 96'(ok), 96'd1);
    check("bp_next_addr", 96'(Needed_Addr), 96'd1);
    wait_done(1'b0, 100, ok);
    finish_sweep("bp");

    // Reset in WAIT of window 5, then a clean restart.
    hs_count = 0;
    done_count = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (need_Data && hs_count == 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_w5", 96'(ok), 96'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    win_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    hs_count = 0;
    done_count = 0;
    pulse_start();
    @(negedge clk);
    check("restart_need", 96'(need_Data), 96'd1);
    check("restart_addr", 96'(Needed_Addr), 96'd0);
    wait_done(1'b0, 100, ok);
    finish_sweep("restart");

    // Random image contents, random backpressure and stray start pulses.
    for (int s = 0; s < 5; s++) begin
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
      hs_count = 0;
      done_count = 0;
      win_ready = 1'b0;
      pulse_start();
      wait_done(1'b1, 600, ok);
      win_ready = 1'b1;
      finish_sweep("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
